radiant_readout_sequencer: RTL
==============================

// Module: radiant_readout_sequencer
// PURPOSE
//  Responder end of the trigger overlord's readout handshake.
//  - Accepts a trigger pulse and issues 1..4 LAB4D readout sequences to the LAB4 controller.
//  - Tracks LAB4 FIFO occupancy in sequences and reports done/full/running back to the overlord.
//  - Emits a header-write strobe with an event number for the DMA/event builder.
// PARAMETERS
//  NSEQ_BITS     2      width of nseq_i; sequences per trigger = nseq_i+1
//  FIFO_SEQ      16     LAB4 FIFO capacity in readout sequences (>= 2**NSEQ_BITS)
//  TIMEOUT_BITS  16     watchdog counter width (RADIANT_SEQ_TIMEOUT_EN only)
// PORTS
//  sys_clk_i          in   1    system clock; only clock
//  sys_rst_n_i        in   1    reset, asynchronous assert, active-low
//  enable_i           in   1    sequencer enable
//  nseq_i             in   NSEQ_BITS  sequences per trigger minus 1; sampled on trigger accept
//  trig_i             in   1    1-cycle trigger pulse from overlord
//  lab_start_o        out  1    1-cycle request for one readout sequence
//  lab_busy_i         in   1    LAB4 controller performing a sequence
//  lab_done_i         in   1    1-cycle: one sequence written into FIFO
//  seq_drained_i      in   1    1-cycle: DMA removed one sequence from FIFO
//  readout_running_o  out  1    sequencer enabled and not in ERROR
//  readout_done_o     out  1    1-cycle: all sequences of current trigger done
//  readout_full_o     out  1    FIFO lacks room for a max-size trigger
//  hdr_wr_o           out  1    1-cycle header strobe at trigger accept
//  event_num_o        out  32   event number for header; valid with hdr_wr_o
//  missed_cnt_o       out  16   triggers dropped because not IDLE (saturating)
//  err_o              out  1    sticky watchdog error
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; occupancy, seq count, event_num, missed_cnt = 0.
//  States:
//  - IDLE: on trig_i&&enable_i&&!readout_full_o: latch nseq_i, pulse hdr_wr_o
//    (event_num_o = current count, then count+1), go START.
//  - START: pulse lab_start_o 1 cycle, go WAIT_BUSY.
//  - WAIT_BUSY: on lab_busy_i go WAIT_DONE; if lab_done_i arrives same cycle, treat as WAIT_DONE exit.
//  - WAIT_DONE: on lab_done_i, if seqs issued == latched nseq+1 go DONE, else START.
//  - DONE: pulse readout_done_o 1 cycle, go IDLE. Trigger-to-first-lab_start_o latency = 2 cycles.
//  - ERROR: entered on watchdog expiry; left only when enable_i=0 (to IDLE, err_o cleared).
//  trig_i outside IDLE, or while full: ignored; missed_cnt_o += 1, saturates at 16'hFFFF.
//  Occupancy counter, width $clog2(FIFO_SEQ+1):
//  - +1 on lab_done_i, -1 on seq_drained_i, unchanged on both together.
//  - drain at 0 saturates at 0; done at FIFO_SEQ saturates.
//  readout_full_o is registered: (occupancy + 2**NSEQ_BITS) > FIFO_SEQ, updated every cycle.
//  enable_i low mid-sequence: abort to IDLE next cycle, no readout_done_o;
//    occupancy and event_num held; a later lab_done_i still counts.
//  readout_running_o = enable_i registered && state!=ERROR (1-cycle latency).
//  Async reset mid-sequence: immediate return to reset values; no pulses emitted.
// CONFIGURATION
//  RADIANT_SEQ_TIMEOUT_EN defined:
//  - watchdog counts cycles in WAIT_BUSY/WAIT_DONE, cleared on each state entry.
//  - at all-ones: err_o=1, state=ERROR.
//  Undefined: no watchdog logic, err_o tied 0, ERROR unreachable.
// STRUCTURE
//  Package radiant_trig_pkg: seq_state_t enum (IDLE,START,WAIT_BUSY,WAIT_DONE,DONE,ERROR),
//    EVENT_NUM_W=32, MISSED_W=16.
//  Sub-module radiant_seq_occupancy: up/down saturating counter plus registered full flag.
// TESTING
//  - nseq_i=0, trig_i, busy 3 cycles then done -> one lab_start_o at +2, readout_done_o once,
//    occupancy 1, event_num_o 0.
//  - nseq_i=3, four busy/done cycles -> exactly 4 lab_start_o, then one readout_done_o, occupancy 4.
//  - Fill to occupancy 13 (FIFO_SEQ=16) -> readout_full_o=1; one seq_drained_i -> full=0 next cycle.
//  - trig_i during WAIT_DONE -> ignored, missed_cnt_o=1, no extra hdr_wr_o;
//    simultaneous lab_done_i+seq_drained_i -> occupancy unchanged.
//  - enable_i low in WAIT_DONE -> IDLE, no readout_done_o, readout_running_o low next cycle.
//  - RADIANT_SEQ_TIMEOUT_EN, TIMEOUT_BITS=4, no lab_busy_i -> err_o after 15 cycles,
//    running=0; enable_i low -> err_o=0.

Source files
------------

// File: rtl/radiant_trig_pkg.sv
// Shared types, widths and helpers for the RADIANT readout sequencer.
package radiant_trig_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } seq_state_t;

  localparam int unsigned EVENT_NUM_W = 32;
  localparam int unsigned MISSED_W    = 16;

  typedef logic [MISSED_W-1:0] missed_cnt_t;

  // Saturating increment for the dropped-trigger counter.
  function automatic missed_cnt_t sat_inc_missed(input missed_cnt_t cnt);
    return (cnt == '1) ? cnt : missed_cnt_t'(cnt + 1'b1);
  endfunction

endpackage

// File: rtl/radiant_readout_sequencer_if.sv
// Overlord / LAB4 controller / DMA handshake bundle seen by the readout sequencer.
interface radiant_readout_sequencer_if #(
  parameter int unsigned NSEQ_BITS = 2
);
  import radiant_trig_pkg::*;

  logic                   enable_i;
  logic [NSEQ_BITS-1:0]   nseq_i;
  logic                   trig_i;
  logic                   lab_start_o;
  logic                   lab_busy_i;
  logic                   lab_done_i;
  logic                   seq_drained_i;
  logic                   readout_running_o;
  logic                   readout_done_o;
  logic                   readout_full_o;
  logic                   hdr_wr_o;
  logic [EVENT_NUM_W-1:0] event_num_o;
  logic [MISSED_W-1:0]    missed_cnt_o;
  logic                   err_o;

  modport master (
    output enable_i, nseq_i, trig_i, lab_busy_i, lab_done_i, seq_drained_i,
    input  lab_start_o, readout_running_o, readout_done_o, readout_full_o,
           hdr_wr_o, event_num_o, missed_cnt_o, err_o
  );

  modport slave (
    input  enable_i, nseq_i, trig_i, lab_busy_i, lab_done_i, seq_drained_i,
    output lab_start_o, readout_running_o, readout_done_o, readout_full_o,
           hdr_wr_o, event_num_o, missed_cnt_o, err_o
  );

endinterface

// File: rtl/radiant_seq_occupancy.sv
// LAB4 FIFO occupancy in readout sequences, with a registered "no room for a
// max-size trigger" flag that tracks the occupancy register cycle for cycle.
module radiant_seq_occupancy #(
  parameter int unsigned NSEQ_BITS = 2,
  parameter int unsigned FIFO_SEQ  = 16,
  parameter int unsigned OCC_W     = $clog2(FIFO_SEQ + 1)
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_n_i,
  input  logic             lab_done_i,
  input  logic             seq_drained_i,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             readout_full_o
);

  localparam int unsigned MAX_SEQ = 32'd1 << NSEQ_BITS;

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             full_q;

  // Up on write, down on drain, both together cancel; saturate at either end.
  always_comb begin
    occ_d = occ_q;
    if (lab_done_i && !seq_drained_i && (occ_q != OCC_W'(FIFO_SEQ))) begin
      occ_d = occ_q + 1'b1;
    end else if (seq_drained_i && !lab_done_i && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      full_q <= (32'(occ_d) + MAX_SEQ) > FIFO_SEQ;
    end
  end

  assign occupancy_o    = occ_q;
  assign readout_full_o = full_q;

endmodule

// File: rtl/radiant_readout_sequencer.sv
// RADIANT readout sequencer: turns overlord triggers into 1..4 LAB4D readout sequences.
// Optional watchdog (ERROR state, err_o) is built when RADIANT_SEQ_TIMEOUT_EN is defined.
module radiant_readout_sequencer
  import radiant_trig_pkg::*;
#(
  parameter int unsigned NSEQ_BITS    = 2,
  parameter int unsigned FIFO_SEQ     = 16,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_n_i,
  radiant_readout_sequencer_if.slave bus
);

  localparam int unsigned SEQ_W = NSEQ_BITS + 1;
  localparam int unsigned OCC_W = $clog2(FIFO_SEQ + 1);

  seq_state_t             state_q, state_d;
  logic [NSEQ_BITS-1:0]   nseq_q, nseq_d;
  logic [SEQ_W-1:0]       issued_q, issued_d;
  logic [EVENT_NUM_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [EVENT_NUM_W-1:0] event_num_q, event_num_d;
  missed_cnt_t            missed_q, missed_d;
  logic                   lab_start_q, lab_start_d;
  logic                   done_q, done_d;
  logic                   hdr_wr_q, hdr_wr_d;
  logic                   running_q, running_d;
  logic [OCC_W-1:0]       occ;
  logic                   full;
  logic                   last_seq_c;
  logic                   wd_expired_c;

  radiant_seq_occupancy #(
    .NSEQ_BITS (NSEQ_BITS),
    .FIFO_SEQ  (FIFO_SEQ),
    .OCC_W     (OCC_W)
  ) u_occ (
    .sys_clk_i      (sys_clk_i),
    .sys_rst_n_i    (sys_rst_n_i),
    .lab_done_i     (bus.lab_done_i),
    .seq_drained_i  (bus.seq_drained_i),
    .occupancy_o    (occ),
    .readout_full_o (full)
  );

  // issued_q already counts the sequence in flight.
  assign last_seq_c = (issued_q == (SEQ_W'(nseq_q) + 1'b1));

  always_comb begin
    state_d     = state_q;
    nseq_d      = nseq_q;
    issued_d    = issued_q;
    evt_cnt_d   = evt_cnt_q;
    event_num_d = event_num_q;
    missed_d    = missed_q;
    lab_start_d = 1'b0;
    done_d      = 1'b0;
    hdr_wr_d    = 1'b0;

    if (bus.trig_i && ((state_q != IDLE) || full)) begin
      missed_d = sat_inc_missed(missed_q);
    end

    case (state_q)
      IDLE: begin
        if (bus.trig_i && bus.enable_i && !full) begin
          nseq_d      = bus.nseq_i;
          issued_d    = '0;
          hdr_wr_d    = 1'b1;
          event_num_d = evt_cnt_q;
          evt_cnt_d   = evt_cnt_q + 1'b1;
          state_d     = START;
        end
      end
      START: begin
        lab_start_d = 1'b1;
        issued_d    = issued_q + 1'b1;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A done arriving together with (or before) busy closes the sequence directly.
        if (bus.lab_done_i) begin
          state_d = last_seq_c ? DONE : START;
        end else if (bus.lab_busy_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.lab_done_i) begin
          state_d = last_seq_c ? DONE : START;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        if (!bus.enable_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts any sequence in progress without a completion pulse.
    if (!bus.enable_i && (state_q != IDLE) && (state_q != ERROR)) begin
      state_d     = IDLE;
      lab_start_d = 1'b0;
      done_d      = 1'b0;
      issued_d    = issued_q;
    end else if (wd_expired_c) begin
      state_d = ERROR;
    end

    running_d = bus.enable_i && (state_d != ERROR);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q     <= IDLE;
      nseq_q      <= '0;
      issued_q    <= '0;
      evt_cnt_q   <= '0;
      event_num_q <= '0;
      missed_q    <= '0;
      lab_start_q <= 1'b0;
      done_q      <= 1'b0;
      hdr_wr_q    <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nseq_q      <= nseq_d;
      issued_q    <= issued_d;
      evt_cnt_q   <= evt_cnt_d;
      event_num_q <= event_num_d;
      missed_q    <= missed_d;
      lab_start_q <= lab_start_d;
      done_q      <= done_d;
      hdr_wr_q    <= hdr_wr_d;
      running_q   <= running_d;
    end
  end

`ifdef RADIANT_SEQ_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic                    err_q;
  logic                    in_wait_c;

  assign in_wait_c    = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign wd_expired_c = in_wait_c && (wd_q == '1);

  // Watchdog restarts on every state change and only runs while waiting on LAB4.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wd_q <= '0;
      end else if (in_wait_c) begin
        wd_q <= wd_q + 1'b1;
      end
      err_q <= (state_d == ERROR);
    end
  end

  assign bus.err_o = err_q;
`else
  assign wd_expired_c = 1'b0;
  assign bus.err_o    = 1'b0;

  // TIMEOUT_BITS only sizes the optional watchdog.
  if (TIMEOUT_BITS == 0) begin : g_no_watchdog_width
  end
`endif

  assign bus.lab_start_o       = lab_start_q;
  assign bus.readout_done_o    = done_q;
  assign bus.hdr_wr_o          = hdr_wr_q;
  assign bus.event_num_o       = event_num_q;
  assign bus.missed_cnt_o      = missed_q;
  assign bus.readout_running_o = running_q;
  assign bus.readout_full_o    = full;

endmodule
